car_pass_gen: RTL and testbench

Sensor-pair stimulus generator for the parking-lot access path. On request it drives the two optical-barrier lines (`botonA`, `botonB`) through the exact phase sequence a car produces when it enters or exits. Its outputs connect directly to the car-passage detector's `botonA`/`botonB` inputs. It serves as the on-board self-test source and as the bench driver for the entry/exit counting chain.

---
 rtl/car_pass_gen.sv | 181 ++++++++++++++++++
 tb/tb_car_pass_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/car_pass_gen.sv
// car_pass_gen: drives the botonA/botonB barrier lines through the phase
// sequence of a car entering or leaving, and counts completed passages.
// Optional feature macro: CARGEN_BACKOUT_EN (aborted passages P1 -> P2 -> P1 -> GAP).
module car_pass_gen #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dir,
  input  logic       backout,
  output logic       botonA,
  output logic       botonB,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [7:0] n_entries,
  output logic [7:0] n_exits
);

  localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GapLoad  = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StP1, StP2, StP3, StGap} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       dir_q, dir_d;
  logic       abort_q, abort_d;
  logic       backout_cap;

  logic       a_q, a_d, b_q, b_d;
  logic       busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic [7:0] n_entries_q, n_entries_d, n_exits_q, n_exits_d;

`ifdef CARGEN_BACKOUT_EN
  assign backout_cap = backout;
`else
  logic unused_backout;
  assign unused_backout = backout;
  assign backout_cap    = 1'b0;
`endif

  // State register: phase FSM, phase counter and captured request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      abort_q <= abort_d;
    end
  end

  // Next-state: advance a phase when the counter hits zero, reloading it on every change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    abort_d = abort_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StP1;
          cnt_d   = HoldLoad;
          dir_d   = dir;
          abort_d = backout_cap;
        end
      end
      StP1: begin
        if (cnt_q == '0) begin
          state_d = StP2;
          cnt_d   = HoldLoad;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StP2: begin
        if (cnt_q == '0) begin
          state_d = StP3;
          cnt_d   = HoldLoad;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StP3: begin
        if (cnt_q == '0) begin
          state_d = StGap;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: decoded from the next state so the registered lines line up with the FSM.
  always_comb begin
    a_d         = 1'b0;
    b_d         = 1'b0;
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StGap) && (cnt_d == '0);
    aborted_d   = 1'b0;
    n_entries_d = n_entries_q;
    n_exits_d   = n_exits_q;
    case (state_d)
      // Entry trips the outer barrier (A) first; exit trips B first.
      StP1: begin
        a_d = ~dir_d;
        b_d = dir_d;
      end
      StP2: begin
        a_d = 1'b1;
        b_d = 1'b1;
      end
      // A backed-out car returns to its first-phase pattern.
      StP3: begin
        a_d = abort_d ? ~dir_d : dir_d;
        b_d = abort_d ? dir_d : ~dir_d;
      end
      default: begin
        a_d = 1'b0;
        b_d = 1'b0;
      end
    endcase
    if (done_d) begin
      aborted_d = abort_d;
      if (!abort_d) begin
        if (dir_d) n_exits_d = n_exits_q + 8'd1;
        else       n_entries_d = n_entries_q + 8'd1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      n_entries_q <= '0;
      n_exits_q   <= '0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      n_entries_q <= n_entries_d;
      n_exits_q   <= n_exits_d;
    end
  end

  assign botonA    = a_q;
  assign botonB    = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign n_entries = n_entries_q;
  assign n_exits   = n_exits_q;

endmodule

// File: tb/tb_car_pass_gen.sv
// Bench for car_pass_gen: directed scenarios plus random requests, checked
// cycle by cycle against a passage-level reference model.
module tb_car_pass_gen;

  localparam int H = 4;
  localparam int G = 2;
`ifdef CARGEN_BACKOUT_EN
  localparam bit AbortEn = 1'b1;
`else
  localparam bit AbortEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic start, dir, backout;
  logic a, b, busy, done, aborted;
  logic [7:0] n_ent, n_ex;
  logic f_start, f_dir, f_backout;
  logic fa, fb, f_busy, f_done, f_aborted;
  logic [7:0] f_nent, f_nex;

  always #5 clk = ~clk;

  car_pass_gen dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .backout(backout),
    .botonA(a), .botonB(b), .busy(busy), .done(done), .aborted(aborted),
    .n_entries(n_ent), .n_exits(n_ex)
  );

  car_pass_gen #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_fast (
    .clk(clk), .reset(reset), .start(f_start), .dir(f_dir), .backout(f_backout),
    .botonA(fa), .botonB(fb), .busy(f_busy), .done(f_done), .aborted(f_aborted),
    .n_entries(f_nent), .n_exits(f_nex)
  );

  typedef struct packed {
    logic a;
    logic b;
    logic done;
    logic abrt;
    logic dir;
  } step_t;

  step_t      q[$];
  step_t      cur;
  logic       cur_busy;
  logic [7:0] ent_m, ex_m;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole passage as a list of per-cycle expectations.
  task automatic push_passage(input logic d, input logic bo);
    logic ab;
    ab = bo & AbortEn;
    for (int i = 0; i < 3 * H + G; i++) begin
      step_t s;
      int ph;
      ph     = i / H;
      s.dir  = d;
      s.abrt = ab;
      s.done = (i == 3 * H + G - 1);
      if (i >= 3 * H) begin
        s.a = 1'b0;
        s.b = 1'b0;
      end else begin
        if (ph == 2 && ab) ph = 0;
        if (ph == 1) begin
          s.a = 1'b1;
          s.b = 1'b1;
        end else if (ph == 0) begin
          s.a = ~d;
          s.b = d;
        end else begin
          s.a = d;
          s.b = ~d;
        end
      end
      q.push_back(s);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_A"}, 8'(a), 8'(cur.a));
    chk({tag, "_B"}, 8'(b), 8'(cur.b));
    chk({tag, "_busy"}, 8'(busy), 8'(cur_busy));
    chk({tag, "_done"}, 8'(done), 8'(cur.done));
    chk({tag, "_aborted"}, 8'(aborted), 8'(cur.done & cur.abrt));
    chk({tag, "_n_entries"}, n_ent, ent_m);
    chk({tag, "_n_exits"}, n_ex, ex_m);
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the next fall.
  task automatic cycle(input string tag, input logic s, input logic d, input logic bo);
    start   = s;
    dir     = d;
    backout = bo;
    @(posedge clk);
    if (!cur_busy && s) push_passage(d, bo);
    if (q.size() > 0) begin
      cur      = q.pop_front();
      cur_busy = 1'b1;
      if (cur.done && !cur.abrt) begin
        if (cur.dir) ex_m = ex_m + 8'd1;
        else         ent_m = ent_m + 8'd1;
      end
    end else begin
      cur      = '0;
      cur_busy = 1'b0;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    q.delete();
    cur      = '0;
    cur_busy = 1'b0;
    ent_m    = '0;
    ex_m     = '0;
    check_outputs(tag);
    chk({tag, "_fast_AB"}, 8'({fa, fb}), 8'd0);
    chk({tag, "_fast_busy"}, 8'(f_busy), 8'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [1:0] fast_pat [4];

  initial begin
    fast_pat  = '{2'b01, 2'b11, 2'b10, 2'b00};
    start     = 1'b0;
    dir       = 1'b0;
    backout   = 1'b0;
    f_start   = 1'b0;
    f_dir     = 1'b0;
    f_backout = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    do_reset("reset");

    // Exit passage with one-cycle phases on the fast instance.
    f_start = 1'b1;
    f_dir   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    f_start = 1'b0;
    f_dir   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fast_AB", 8'({fa, fb}), 8'(fast_pat[i]));
      chk("fast_busy", 8'(f_busy), 8'd1);
      chk("fast_done", 8'(f_done), (i == 3) ? 8'd1 : 8'd0);
      chk("fast_n_exits", f_nex, (i == 3) ? 8'd1 : 8'd0);
      chk("fast_n_entries", f_nent, 8'd0);
      @(negedge clk);
    end
    chk("fast_idle", 8'(f_busy), 8'd0);

    // Entry passage with default timing; dir/backout wiggle after capture.
    cycle("entry", 1'b1, 1'b0, 1'b0);
    repeat (14) cycle("entry", 1'b0, 1'b1, 1'b1);
    cycle("entry_idle", 1'b0, 1'b0, 1'b0);
    chk("entry_count", n_ent, 8'd1);

    // Start held high: two passages accepted, separated by an idle cycle.
    repeat (30) cycle("held", 1'b1, 1'b0, 1'b0);
    repeat (2) cycle("held_tail", 1'b0, 1'b0, 1'b0);
    chk("held_count", n_ent, 8'd3);

    // Reset in P2, then a clean passage.
    cycle("pre_rst", 1'b1, 1'b0, 1'b0);
    repeat (5) cycle("pre_rst", 1'b0, 1'b0, 1'b0);
    do_reset("mid_reset");
    cycle("post_rst", 1'b1, 1'b0, 1'b0);
    repeat (15) cycle("post_rst", 1'b0, 1'b0, 1'b0);
    chk("post_rst_count", n_ent, 8'd1);

    // Backout request: aborted when the feature is built in, normal otherwise.
    cycle("backout", 1'b1, 1'b0, 1'b1);
    repeat (15) cycle("backout", 1'b0, 1'b0, 1'b0);

    // Random requests.
    repeat (400) cycle("rand", ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));

    // Counter wrap: 256 entries from reset.
    do_reset("wrap_reset");
    for (int p = 0; p < 256; p++) begin
      cycle("wrap", 1'b1, 1'b0, 1'b0);
      repeat (14) cycle("wrap", 1'b0, 1'($urandom), 1'($urandom));
    end
    cycle("wrap_idle", 1'b0, 1'b0, 1'b0);
    chk("wrap_n_entries", n_ent, 8'd0);
    chk("wrap_n_exits", n_ex, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
